mips_avalon_arbiter: RTL and testbench

// - Shares one Avalon-MM master port between NUM_MASTERS requesters: instr refill (0), data refill (1), write-buffer drain (2).
// - Sits between the cache/write-buffer side and the memory bus, and replaces ad-hoc muxing of mem_address/mem_read/mem_write.
// - Each requester keeps the Avalon waitrequest protocol. Grant is registered and held for a whole transaction.

---
 rtl/mips_arb_pkg.sv | 21 ++
 rtl/mips_arb_priority_pick.sv | 31 +++
 rtl/mips_avalon_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// Shared types and sizing helpers for the MIPS Avalon-MM bus arbiter.
//   arb_state_t             : arbiter FSM state encoding
//   ARB_NUM_MASTERS_DEFAULT : default requester count (instr refill, data refill, wb drain)
//   arb_idx_w()             : width of a requester index (never below 1 bit)
//   ARB_IDX_W               : index width for the default requester count
package mips_arb_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_MASTERS_DEFAULT = 3;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ARB_IDX_W = arb_idx_w(ARB_NUM_MASTERS_DEFAULT);

endpackage

// File: rtl/mips_arb_priority_pick.sv
// Combinational fixed-priority picker. Candidates are req & starved; the
// lowest-index candidate wins. Tying starved to all-ones gives plain fixed
// priority, so the same block serves both the starved and the normal level.
// Ports:
//   req     in  N      per-master request
//   starved in  N      per-master qualifier (all-ones = no qualification)
//   winner  out IDX_W  index of the lowest qualified requester (0 if none)
//   any_req out 1      at least one qualified requester exists
module mips_arb_priority_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     starved,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [N-1:0] cand;

  always_comb begin
    cand    = req & starved;
    any_req = |cand;
    winner  = '0;
    // Scan from the top so the lowest index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) winner = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon-MM master port between NUM_MASTERS requesters
// (0 = instr refill, 1 = data refill, 2 = write-buffer drain). The grant is
// registered in an IDLE arbitration cycle and held for the whole transfer;
// one dead IDLE cycle separates back-to-back transactions.
// Optional feature: define MIPS_ARB_AGING_EN to add per-master saturating
// wait counters; a master waiting MAX_WAIT cycles or more outranks all
// non-starved masters. Without it the arbiter is strict fixed priority.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m_address/m_read/m_write/
//   m_writedata/m_byteenable      per-master Avalon requests (packed, master i at slice i)
//   m_waitrequest                 per-master stall (1 for everyone but the active owner)
//   m_readdata                    slave read data broadcast
//   mem_*                         shared Avalon port towards the slave
//   waitrequest, mem_readdata     slave responses
//   grant_idx                     current/last owner
//   busy                          high while a transfer is in flight
module mips_avalon_arbiter
  import mips_arb_pkg::*;
#(
  parameter int NUM_MASTERS = ARB_NUM_MASTERS_DEFAULT,
  parameter int MAX_WAIT    = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [32*NUM_MASTERS-1:0]         m_address,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [32*NUM_MASTERS-1:0]         m_writedata,
  input  logic [4*NUM_MASTERS-1:0]          m_byteenable,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [31:0]                       m_readdata,
  output logic [31:0]                       mem_address,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [31:0]                       mem_writedata,
  output logic [3:0]                        mem_byteenable,
  input  logic                              waitrequest,
  input  logic [31:0]                       mem_readdata,
  output logic [arb_idx_w(NUM_MASTERS)-1:0] grant_idx,
  output logic                              busy
);

  localparam int IDX_W = arb_idx_w(NUM_MASTERS);

  if (NUM_MASTERS < 2 || MAX_WAIT < 1) begin : g_param_check
    $error("mips_avalon_arbiter: NUM_MASTERS must be >= 2 and MAX_WAIT >= 1");
  end

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt_vec;   // one-hot owner, only while BUSY
  logic [NUM_MASTERS-1:0] grant_now; // one-hot winner of this IDLE cycle
  logic [IDX_W-1:0]       idx_all;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any_req;
  logic                   owner_req;

  assign req = m_read | m_write;

  mips_arb_priority_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_all (
    .req     (req),
    .starved ({NUM_MASTERS{1'b1}}),
    .winner  (idx_all),
    .any_req (any_req)
  );

`ifdef MIPS_ARB_AGING_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]       wait_cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] starved;
  logic [IDX_W-1:0]       idx_stv;
  logic                   any_stv;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      starved[i] = (wait_cnt[i] >= CNT_W'(MAX_WAIT));
    end
  end

  mips_arb_priority_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_stv (
    .req     (req),
    .starved (starved),
    .winner  (idx_stv),
    .any_req (any_stv)
  );

  assign pick_idx = any_stv ? idx_stv : idx_all;

  // Counters age every cycle a master asks but does not own the bus,
  // including the IDLE arbitration cycle it loses; winning clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTERS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_now[i]) begin
          wait_cnt[i] <= '0;
        end else if (req[i] && !gnt_vec[i] && (wait_cnt[i] != '1)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign pick_idx = idx_all;
`endif

  always_comb begin
    gnt_vec   = '0;
    grant_now = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt_vec[i]   = (state == STATE_BUSY) && (grant_idx == IDX_W'(i));
      grant_now[i] = (state == STATE_IDLE) && any_req && (pick_idx == IDX_W'(i));
    end
    owner_req = |(req & gnt_vec);
  end

  // Arbitration FSM: grant and busy are registered together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_IDLE;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (any_req) begin
            grant_idx <= pick_idx;
            state     <= STATE_BUSY;
            busy      <= 1'b1;
          end
        end
        STATE_BUSY: begin
          // Completion, or the owner abandoned its request.
          if (!waitrequest || !owner_req) begin
            state <= STATE_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= STATE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output mux: only the owner reaches the slave and sees its waitrequest.
  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    m_waitrequest  = '1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_vec[i]) begin
        mem_address      = m_address[32*i +: 32];
        mem_read         = m_read[i];
        mem_write        = m_write[i];
        mem_writedata    = m_writedata[32*i +: 32];
        mem_byteenable   = m_byteenable[4*i +: 4];
        m_waitrequest[i] = waitrequest;
      end
    end
  end

  assign m_readdata = mem_readdata;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    ((m_read & m_write) == '0));

  a_owner_holds: assert property (@(posedge clk) disable iff (rst)
    (state == STATE_BUSY) |-> owner_req);

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
module tb_mips_avalon_arbiter;
  import mips_arb_pkg::*;

  localparam int N = ARB_NUM_MASTERS_DEFAULT;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [32*N-1:0]      m_address;
  logic [N-1:0]         m_read;
  logic [N-1:0]         m_write;
  logic [32*N-1:0]      m_writedata;
  logic [4*N-1:0]       m_byteenable;
  logic [N-1:0]         m_waitrequest;
  logic [31:0]          m_readdata;
  logic [31:0]          mem_address;
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          mem_writedata;
  logic [3:0]           mem_byteenable;
  logic                 waitrequest;
  logic [31:0]          mem_readdata;
  logic [ARB_IDX_W-1:0] grant_idx;
  logic                 busy;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.NUM_MASTERS(N), .MAX_WAIT(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .waitrequest    (waitrequest),
    .mem_readdata   (mem_readdata),
    .grant_idx      (grant_idx),
    .busy           (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs held for the cycle, outputs expected mid-cycle.
  typedef struct {
    logic        rstv;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic        wreq;
    logic        busy;
    logic        mrd;
    logic        mwr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [2:0]  mwait;
    logic [1:0]  gidx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rstv, input logic [2:0] rd, input logic [2:0] wr,
                     input logic wreq, input logic b, input logic mrd, input logic mwr,
                     input logic [31:0] addr, input logic [3:0] be,
                     input logic [2:0] mwait, input logic [1:0] gidx);
    vec_t v;
    v.rstv = rstv; v.rd = rd; v.wr = wr; v.wreq = wreq;
    v.busy = b; v.mrd = mrd; v.mwr = mwr; v.addr = addr; v.be = be;
    v.mwait = mwait; v.gidx = gidx;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       got2, drop2, prev_busy, drained;
    int         rounds, grant_round;

    rst          = 1'b1;
    m_read       = '0;
    m_write      = '0;
    waitrequest  = 1'b0;
    mem_readdata = 32'hDEADBEEF;
    m_address    = {32'h0000_0020, 32'h0000_1000, 32'h0000_0400};
    m_writedata  = {32'h1234_5678, 32'h2222_2222, 32'h1111_1111};
    m_byteenable = {4'b0011, 4'b1111, 4'b1111};

    //   rst rd      wr      wq  busy rd wr addr           be      mwait   g
    // reset
    add(1, 3'b000, 3'b000, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd0);
    add(1, 3'b000, 3'b000, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd0);
    // single read by master 1, slave stalls two cycles
    add(0, 3'b010, 3'b000, 1,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd0);
    add(0, 3'b010, 3'b000, 1,  1, 1, 0, 32'h1000,     4'hF,   3'b111, 2'd1);
    add(0, 3'b010, 3'b000, 1,  1, 1, 0, 32'h1000,     4'hF,   3'b111, 2'd1);
    add(0, 3'b010, 3'b000, 0,  1, 1, 0, 32'h1000,     4'hF,   3'b101, 2'd1);
    add(0, 3'b000, 3'b000, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd1);
    // write passthrough by master 2
    add(0, 3'b000, 3'b100, 1,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd1);
    add(0, 3'b000, 3'b100, 1,  1, 0, 1, 32'h20,       4'b0011, 3'b111, 2'd2);
    add(0, 3'b000, 3'b100, 0,  1, 0, 1, 32'h20,       4'b0011, 3'b011, 2'd2);
    add(0, 3'b000, 3'b000, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd2);
    // contention: all three at once, zero-wait slave
    add(0, 3'b011, 3'b100, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd2);
    add(0, 3'b011, 3'b100, 0,  1, 1, 0, 32'h400,      4'hF,   3'b110, 2'd0);
    add(0, 3'b010, 3'b100, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd0);
    add(0, 3'b010, 3'b100, 0,  1, 1, 0, 32'h1000,     4'hF,   3'b101, 2'd1);
    add(0, 3'b000, 3'b100, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd1);
    add(0, 3'b000, 3'b100, 0,  1, 0, 1, 32'h20,       4'b0011, 3'b011, 2'd2);
    add(0, 3'b000, 3'b000, 0,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd2);
    // idle for ten cycles
    for (int i = 0; i < 10; i++)
      add(0, 3'b000, 3'b000, 0, 0, 0, 0, 32'h0, 4'h0, 3'b111, 2'd2);
    // reset while master 1 is stalled mid-transfer
    add(0, 3'b010, 3'b000, 1,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd2);
    add(0, 3'b010, 3'b000, 1,  1, 1, 0, 32'h1000,     4'hF,   3'b111, 2'd1);
    add(1, 3'b010, 3'b000, 1,  1, 1, 0, 32'h1000,     4'hF,   3'b111, 2'd1);
    add(0, 3'b000, 3'b000, 1,  0, 0, 0, 32'h0,        4'h0,   3'b111, 2'd0);

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      rst         = tbl[k].rstv;
      m_read      = tbl[k].rd;
      m_write     = tbl[k].wr;
      waitrequest = tbl[k].wreq;
      @(negedge clk);
      check($sformatf("busy[%0d]", k),       32'(busy),           32'(tbl[k].busy));
      check($sformatf("mem_read[%0d]", k),   32'(mem_read),       32'(tbl[k].mrd));
      check($sformatf("mem_write[%0d]", k),  32'(mem_write),      32'(tbl[k].mwr));
      check($sformatf("mem_addr[%0d]", k),   mem_address,         tbl[k].addr);
      check($sformatf("mem_be[%0d]", k),     32'(mem_byteenable), 32'(tbl[k].be));
      check($sformatf("m_waitreq[%0d]", k),  32'(m_waitrequest),  32'(tbl[k].mwait));
      check($sformatf("grant_idx[%0d]", k),  32'(grant_idx),      32'(tbl[k].gidx));
      if ((tbl[k].rd & ~tbl[k].mwait) != 3'b000)
        check($sformatf("m_readdata[%0d]", k), m_readdata, 32'hDEADBEEF);
      if (tbl[k].mwr)
        check($sformatf("mem_wdata[%0d]", k), mem_writedata, 32'h1234_5678);
    end

    // Aging: master 0 re-requests forever, master 2 holds a write.
    got2 = 1'b0; drop2 = 1'b0; prev_busy = 1'b0; rounds = 0; grant_round = 0;
    @(posedge clk); #1;
    m_read = 3'b001; m_write = 3'b100; waitrequest = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) rounds++;
      prev_busy = busy;
      if (busy && grant_idx == 2'd2) begin
        if (!got2) grant_round = rounds;
        got2  = 1'b1;
        drop2 = 1'b1;
      end
      @(posedge clk); #1;
      if (drop2) m_write = 3'b000;
    end
    check("aging_rounds_seen", 32'(rounds >= 4), 32'd1);
`ifdef MIPS_ARB_AGING_EN
    check("aging_m2_granted", 32'(got2), 32'd1);
    check("aging_m2_round_le4", 32'(got2 && grant_round <= 4), 32'd1);
`else
    check("fixed_m2_starved", 32'(got2), 32'd0);
`endif

    // Release master 0 (and any held write) at the start of an IDLE cycle.
    drained = 1'b0;
    for (int c = 0; c < 8 && !drained; c++) begin
      @(negedge clk);
      if (busy) drained = 1'b1;
      @(posedge clk); #1;
      if (drained) begin
        m_read  = 3'b000;
        m_write = 3'b000;
      end
    end
    check("drain_done", 32'(drained), 32'd1);
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_mem_read", 32'(mem_read), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
